// File: rtl/output_layer_pkg.sv
// Shared types and constants for the drowsiness-detector output layer.
// Holds the state encoding, layer sizes, default weights and PLAN breakpoints.
package outlayer_pkg;

    localparam int N_HID = 5;
    localparam int N_OUT = 3;
    localparam int WGT_W = 10;
    localparam int ACC_W = 24;
    localparam int N_WGT = 18;
    localparam int Z_W   = ACC_W - 8;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_MAC  = 4'd1,
        S_ACT  = 4'd2,
        S_ARG  = 4'd3,
        S_DONE = 4'd4
    } state_t;

    // PLAN breakpoints and offsets, all in Q.10 (x1024)
    localparam logic [Z_W:0] PLAN_SAT  = (Z_W+1)'(5120);
    localparam logic [Z_W:0] PLAN_BP2  = (Z_W+1)'(2432);
    localparam logic [Z_W:0] PLAN_BP1  = (Z_W+1)'(1024);
    localparam logic [Z_W:0] PLAN_OFF2 = (Z_W+1)'(864);
    localparam logic [Z_W:0] PLAN_OFF1 = (Z_W+1)'(640);
    localparam logic [Z_W:0] PLAN_OFF0 = (Z_W+1)'(512);
    localparam logic [Z_W:0] PLAN_ONE  = (Z_W+1)'(1024);
    localparam logic [Z_W:0] PLAN_MAXV = (Z_W+1)'(1023);

    // Default weight table, index n*6+k, k=5 is the bias (signed Q2.8)
    function automatic logic [WGT_W-1:0] default_wgt(input logic [4:0] idx);
        case (idx)
            5'd0:    return 10'h100;
            5'd8:    return 10'h1FF;
            5'd11:   return 10'h080;
            5'd13:   return 10'h380;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/output_layer_if.sv
// Handshake, weight-load and result bus of the output layer.
interface output_layer_if;
    import outlayer_pkg::*;

    logic                        Start;
    logic [N_HID-1:0][9:0]       hidVal;
    logic                        WE;
    logic [4:0]                  wAddr;
    logic [WGT_W-1:0]            wData;
    logic [N_OUT-1:0][9:0]       outVal1;
    logic [1:0]                  cls;
    logic                        Done;
    logic                        Busy;
    logic [3:0]                  state;
    logic [4:0]                  address;

    modport master (
        output Start, hidVal, WE, wAddr, wData,
        input  outVal1, cls, Done, Busy, state, address
    );

    modport slave (
        input  Start, hidVal, WE, wAddr, wData,
        output outVal1, cls, Done, Busy, state, address
    );
endinterface

// File: rtl/output_layer_plan_sigmoid.sv
// Piecewise-linear (PLAN) sigmoid: signed Q.10 in, unsigned Q0.10 out, truncating.
module plan_sigmoid
    import outlayer_pkg::*;
(
    input  logic signed [Z_W-1:0] i_z,
    output logic        [9:0]     o_y
);
    logic [Z_W:0] w_a;
    logic [Z_W:0] w_pos;
    logic [Z_W:0] w_y;

    always_comb begin
        // one extra bit so the most negative input has a representable magnitude
        w_a = i_z[Z_W-1] ? ((Z_W+1)'(0) - {i_z[Z_W-1], i_z}) : {1'b0, i_z};
        if (w_a >= PLAN_SAT)      w_pos = PLAN_ONE;
        else if (w_a >= PLAN_BP2) w_pos = (w_a >> 5) + PLAN_OFF2;
        else if (w_a >= PLAN_BP1) w_pos = (w_a >> 3) + PLAN_OFF1;
        else                      w_pos = (w_a >> 2) + PLAN_OFF0;
        w_y = i_z[Z_W-1] ? (PLAN_ONE - w_pos) : w_pos;
        o_y = (w_y > PLAN_MAXV) ? 10'd1023 : w_y[9:0];
    end
endmodule

// File: rtl/output_layer.sv
// Output layer: sequential MAC over 5 hidden inputs x 3 neurons, PLAN sigmoid, argmax.
// Optional run-time weight loading is enabled by defining OUTLAYER_WLOAD_EN.
module output_layer
    import outlayer_pkg::*;
(
    input  logic          Clock,
    input  logic          Rst,
    output_layer_if.slave bus
);
    state_t                   r_state, w_next;
    logic [1:0]               r_n;
    logic [2:0]               r_k;
    logic [N_HID-1:0][9:0]    r_hid;
    logic signed [ACC_W-1:0]  r_acc;
    logic [N_OUT-1:0][9:0]    r_out;
    logic [1:0]               r_cls;

    logic [4:0]               w_addr;
    logic [WGT_W-1:0]         w_wgt;
    logic [9:0]               w_hsel;
    logic signed [20:0]       w_prod;
    logic signed [ACC_W-1:0]  w_term;
    logic [9:0]               w_y;
    logic [1:0]               w_cls;

    assign w_addr = 5'(r_n) * 5'd6 + 5'(r_k);

`ifdef OUTLAYER_WLOAD_EN
    logic [WGT_W-1:0] r_wgt [N_WGT];

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < N_WGT; i++) r_wgt[i] <= default_wgt(5'(i));
        end else if (bus.WE && (bus.wAddr < 5'(N_WGT))) begin
            r_wgt[bus.wAddr] <= bus.wData;
        end
    end

    assign w_wgt = r_wgt[w_addr];
`else
    logic w_unused;
    assign w_unused = ^{bus.WE, bus.wAddr, bus.wData};
    assign w_wgt    = default_wgt(w_addr);
`endif

    always_comb begin
        case (r_k)
            3'd0:    w_hsel = r_hid[0];
            3'd1:    w_hsel = r_hid[1];
            3'd2:    w_hsel = r_hid[2];
            3'd3:    w_hsel = r_hid[3];
            3'd4:    w_hsel = r_hid[4];
            default: w_hsel = '0;
        endcase
        w_prod = $signed({1'b0, w_hsel}) * $signed(w_wgt);
        // bias is Q2.8; shifting by 10 aligns it with the Q.18 products
        if (r_k == 3'd5) w_term = {{4{w_wgt[WGT_W-1]}}, w_wgt, 10'b0};
        else             w_term = {{3{w_prod[20]}}, w_prod};
    end

    plan_sigmoid u_plan (
        .i_z (r_acc[ACC_W-1:8]),
        .o_y (w_y)
    );

    always_comb begin
        w_cls = 2'd0;
        if (r_out[1] > r_out[0]) w_cls = 2'd1;
        if (r_out[2] > r_out[w_cls]) w_cls = 2'd2;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.Start) w_next = S_MAC;
            S_MAC:   if (r_k == 3'd5) w_next = S_ACT;
            S_ACT:   w_next = (r_n == 2'd2) ? S_ARG : S_MAC;
            S_ARG:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            r_n   <= '0;
            r_k   <= '0;
            r_hid <= '0;
            r_acc <= '0;
            r_out <= '0;
            r_cls <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.Start) begin
                    r_hid <= bus.hidVal;
                    r_acc <= '0;
                    r_n   <= '0;
                    r_k   <= '0;
                end
                S_MAC: begin
                    r_acc <= r_acc + w_term;
                    if (r_k != 3'd5) r_k <= r_k + 3'd1;
                end
                S_ACT: begin
                    r_out[r_n] <= w_y;
                    if (r_n != 2'd2) begin
                        r_n   <= r_n + 2'd1;
                        r_k   <= '0;
                        r_acc <= '0;
                    end
                end
                S_ARG:   r_cls <= w_cls;
                default: ;
            endcase
        end
    end

    assign bus.outVal1 = r_out;
    assign bus.cls     = r_cls;
    assign bus.Done    = (r_state == S_DONE);
    assign bus.Busy    = (r_state != S_IDLE);
    assign bus.state   = r_state;
    assign bus.address = w_addr;
endmodule

// File: tb/tb_output_layer.sv
// Directed, table-driven bench for output_layer (default weights; WLOAD cases when OUTLAYER_WLOAD_EN is set).
module tb_output_layer;
    import outlayer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    output_layer_if bif ();

    output_layer dut (
        .Clock (clk),
        .Rst   (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0][9:0] hid;
        logic [9:0]      o0, o1, o2;
        logic [1:0]      cls;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Pulse Start at edge E0 and return the number of edges until Done is seen.
    task automatic run_pass(input logic [4:0][9:0] hid, output int lat);
        bif.hidVal = hid;
        bif.Start  = 1'b1;
        @(posedge clk); #1;
        bif.Start  = 1'b0;
        lat = 0;
        while (bif.Done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        int lat;
        run_pass(v.hid, lat);
        chk({tag, "_latency"}, lat, 22);
        chk({tag, "_out0"}, bif.outVal1[0], v.o0);
        chk({tag, "_out1"}, bif.outVal1[1], v.o1);
        chk({tag, "_out2"}, bif.outVal1[2], v.o2);
        chk({tag, "_cls"}, bif.cls, v.cls);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, bif.Done, 1'b0);
        chk({tag, "_idle"}, bif.state, 4'd0);
    endtask

`ifdef OUTLAYER_WLOAD_EN
    task automatic wr(input logic [4:0] addr, input logic [9:0] data);
        bif.WE    = 1'b1;
        bif.wAddr = addr;
        bif.wData = data;
        @(posedge clk); #1;
        bif.WE    = 1'b0;
    endtask
`endif

    vec_t tbl [6];
    vec_t v;

    initial begin
        int lat, ndone, first;
        rst_n      = 1'b0;
        bif.Start  = 1'b0;
        bif.hidVal = '0;
        bif.WE     = 1'b0;
        bif.wAddr  = '0;
        bif.wData  = '0;

        // default weights: w0=1.0, w8=0x1FF, bias1=0.5, w13=-0.5
        tbl[0] = '{hid: {10'd0, 10'd0, 10'd0, 10'd0, 10'd0},       o0: 512, o1: 640, o2: 512, cls: 1};
        tbl[1] = '{hid: {10'd0, 10'd0, 10'd0, 10'd0, 10'd1023},    o0: 767, o1: 640, o2: 512, cls: 0};
        tbl[2] = '{hid: {10'd0, 10'd0, 10'd0, 10'd1000, 10'd512},  o0: 640, o1: 640, o2: 387, cls: 0};
        tbl[3] = '{hid: {10'd0, 10'd0, 10'd0, 10'd1023, 10'd100},  o0: 537, o1: 640, o2: 384, cls: 1};
        tbl[4] = '{hid: {10'd333, 10'd777, 10'd1023, 10'd1, 10'd1023}, o0: 767, o1: 943, o2: 512, cls: 1};
        tbl[5] = '{hid: {10'd0, 10'd0, 10'd400, 10'd0, 10'd0},     o0: 512, o1: 803, o2: 512, cls: 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", bif.state, 4'd0);
        chk("rst_done", bif.Done, 1'b0);
        chk("rst_busy", bif.Busy, 1'b0);
        chk("rst_out", bif.outVal1, 30'd0);
        chk("rst_cls", bif.cls, 2'd0);
        chk("rst_addr", bif.address, 5'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) check_vec($sformatf("vec%0d", i), tbl[i]);

        // reset in the middle of a pass
        bif.hidVal = tbl[4].hid;
        bif.Start  = 1'b1;
        @(posedge clk); #1;
        bif.Start  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_busy_before", bif.Busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_state", bif.state, 4'd0);
        chk("midrst_busy", bif.Busy, 1'b0);
        chk("midrst_out", bif.outVal1, 30'd0);
        chk("midrst_cls", bif.cls, 2'd0);
        chk("midrst_addr", bif.address, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (bif.Done === 1'b1) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        check_vec("after_rst", tbl[1]);

        // second Start at E5 must be ignored
        bif.hidVal = tbl[4].hid;
        bif.Start  = 1'b1;
        @(posedge clk); #1;
        bif.Start  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bif.hidVal = tbl[2].hid;
        bif.Start  = 1'b1;
        @(posedge clk); #1;
        bif.Start  = 1'b0;
        ndone = 0;
        first = -1;
        for (int c = 6; c < 45; c++) begin
            @(posedge clk); #1;
            if (bif.Done === 1'b1) begin
                ndone++;
                if (first < 0) first = c;
            end
            if (c == 22) begin
                chk("busy_start_out0", bif.outVal1[0], 10'd767);
                chk("busy_start_out1", bif.outVal1[1], 10'd943);
                chk("busy_start_out2", bif.outVal1[2], 10'd512);
                chk("busy_start_cls", bif.cls, 2'd1);
            end
        end
        chk("busy_start_ndone", ndone, 1);
        chk("busy_start_when", first, 22);

`ifdef OUTLAYER_WLOAD_EN
        for (int i = 0; i < 18; i++) wr(5'(i), 10'h000);
        wr(5'd11, 10'h100);
        wr(5'd17, 10'h180);
        v = '{hid: {10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023}, o0: 512, o1: 768, o2: 832, cls: 2};
        check_vec("bias_only", v);

        wr(5'd5, 10'h200);
        wr(5'd11, 10'h000);
        wr(5'd17, 10'h000);
        v = '{hid: {10'd0, 10'd0, 10'd0, 10'd0, 10'd0}, o0: 128, o1: 512, o2: 512, cls: 1};
        check_vec("neg_bias", v);

        wr(5'd5, 10'h000);
        wr(5'd0, 10'h100);
        v = '{hid: {10'd0, 10'd0, 10'd0, 10'd0, 10'd512}, o0: 640, o1: 512, o2: 512, cls: 0};
        check_vec("mac_path", v);
        v.hid = {10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd512};
        check_vec("mac_path_other_hid", v);

        for (int i = 0; i < 18; i++) wr(5'(i), 10'h0FF);
        v = '{hid: {10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023}, o0: 1023, o1: 1023, o2: 1023, cls: 0};
        check_vec("sat_tie", v);

        wr(5'd18, 10'h200);
        wr(5'd31, 10'h200);
        check_vec("waddr_oob", v);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
